alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, 32, operand/result width in bits.
REQ-003 clk_i  input  1  clock, all state on rising edge.
REQ-004 rst_n_i  input  1  asynchronous active-low reset.
REQ-005 valid_i  input  1  request valid.
REQ-006 ready_o  output  1  unit can accept a request this cycle.
REQ-007 alu_op_i  input  3  operation code from ALU control (000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 LW, 101 SW, 110 BR, 111 J).
REQ-008 a_i  input  WIDTH  operand A.
REQ-009 b_i  input  WIDTH  operand B.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts result.
REQ-012 result_o  output  WIDTH  result.
REQ-013 zero_o  output  1  result_o == 0.
REQ-014 div_by_zero_o  output  1  DIV with b == 0.
REQ-015 busy_o  output  1  MUL or DIV iteration in progress.

Function
REQ-016 Transfer in SHALL occur when valid_i && ready_o; transfer out when valid_o && ready_i.
REQ-017 States SHALL be IDLE, MUL, DIV, DONE.
REQ-018 ready_o SHALL be 1 in IDLE, and in DONE only while ready_i = 1 (combinational path from ready_i); 0 in MUL/DIV.
REQ-019 ADD, LW, SW SHALL compute a + b modulo 2^WIDTH; SUB and BR SHALL compute a - b modulo 2^WIDTH; J SHALL pass b through.
REQ-020 Single-cycle ops accepted in cycle N SHALL present valid_o = 1 with result in cycle N+1 (state DONE).
REQ-021 MUL SHALL be unsigned iterative shift-add, one bit per cycle, producing the low WIDTH bits of the product; accepted in cycle N, valid_o in cycle N+WIDTH+1.
REQ-022 DIV SHALL be unsigned restoring division, one quotient bit per cycle, result = quotient; accepted in N, valid_o in N+WIDTH+1.
REQ-023 DIV with b == 0 SHALL skip iteration: valid_o in N+1, result all ones, div_by_zero_o = 1.
REQ-024 An iteration counter of clog2(WIDTH)+1 bits SHALL count 0..WIDTH-1; MUL/DIV SHALL exit to DONE when it reaches WIDTH-1.
REQ-025 result_o, zero_o, div_by_zero_o SHALL be registered and held stable while valid_o = 1 and ready_i = 0.
REQ-026 In DONE with ready_i = 1 and valid_i = 1, a new request SHALL be accepted the same cycle (back-to-back, no bubble); with ready_i = 1 and valid_i = 0, next state IDLE.
REQ-027 div_by_zero_o SHALL be 0 for every op other than DIV by zero.
REQ-028 busy_o SHALL be 1 exactly in states MUL and DIV.
REQ-029 Operands SHALL be captured on acceptance; a_i/b_i/alu_op_i changes afterwards SHALL not affect the in-flight result.

Reset
REQ-030 On rst_n_i = 0, state SHALL go to IDLE immediately; valid_o, busy_o, div_by_zero_o, zero_o = 0; result_o = 0; counter = 0.
REQ-031 Reset asserted mid-MUL/DIV SHALL abort the operation with no result ever presented.

Structure
REQ-032 Op-code constants, state encoding and WIDTH default SHALL live in a shared package alu_pkg, also used by ALU control.
REQ-033 The MUL/DIV datapath (accumulator, shift registers, counter) SHALL be one sub-module alu_iter_muldiv; FSM, single-cycle ops and handshake stay in alu_exec_unit.

Verification
REQ-034 ADD a=32'hFFFF_FFFF, b=1, ready_i=1 -> valid_o next cycle, result 0, zero_o 1.
REQ-035 MUL a=7, b=6 -> busy_o 32 cycles, valid_o at N+33, result 42; MUL 32'h1_0000 × 32'h1_0000 -> result 0.
REQ-036 DIV a=100, b=7 -> result 14 at N+33; DIV a=5, b=0 -> N+1, result 32'hFFFF_FFFF, div_by_zero_o 1.
REQ-037 BR a=b=32'h1234 -> result 0, zero_o 1; then ready_i=0 for 5 cycles -> outputs held, ready_o 0.
REQ-038 Back-to-back SUB 10-3 then J b=32'h400 with ready_i=1 -> results 7 and 32'h400 in consecutive cycles.
REQ-039 Reset pulsed at cycle 10 of a DIV -> IDLE, valid_o never asserts, next ADD 2+2 returns 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encoding, execution-unit state encoding, default width.
// Also used by the ALU control decoder.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_LW  = 3'b100,
        OP_SW  = 3'b101,
        OP_BR  = 3'b110,
        OP_J   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } alu_state_e;

    // State entered when a request with this op is accepted; DIV by zero skips iteration.
    function automatic alu_state_e issue_state(input alu_op_e op, input logic b_zero);
        alu_state_e st;
        st = ST_DONE;
        if (op == OP_MUL) begin
            st = ST_MUL;
        end else if (op == OP_DIV && !b_zero) begin
            st = ST_DIV;
        end
        return st;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per step.
// The same three registers serve both: acc = product/remainder, opa = multiplicand/quotient, opb = multiplier/divisor.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_c,
    output logic             last_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc, opa, opb;
    logic [WIDTH-1:0] acc_n, opa_n, opb_n;
    logic [WIDTH:0]   rem_sh, diff;
    logic [CNT_W-1:0] cnt;
    logic             mode_div;

    // One iteration step; result_c is the value the step is about to commit.
    always_comb begin
        acc_n  = acc;
        opa_n  = opa;
        opb_n  = opb;
        rem_sh = {acc, opa[WIDTH-1]};
        diff   = rem_sh - {1'b0, opb};
        if (mode_div) begin
            if (!diff[WIDTH]) begin
                acc_n = diff[WIDTH-1:0];
                opa_n = {opa[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = rem_sh[WIDTH-1:0];
                opa_n = {opa[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (opb[0]) begin
                acc_n = acc + opa;
            end
            opa_n = {opa[WIDTH-2:0], 1'b0};
            opb_n = {1'b0, opb[WIDTH-1:1]};
        end
        result_c = mode_div ? opa_n : acc_n;
    end

    assign last_c = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            cnt      <= '0;
            mode_div <= 1'b0;
        end else if (start) begin
            acc      <= '0;
            opa      <= a;
            opb      <= b;
            cnt      <= '0;
            mode_div <= is_div;
        end else if (step) begin
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready handshake, single-cycle ops, and control of the
// iterative MUL/DIV datapath. Results are registered and held until consumed.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       alu_op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             div_by_zero_o,
    output logic             busy_o
);

    alu_state_e       state, state_n;
    alu_op_e          op_c;
    logic             accept_c, b_zero_c, iter_start_c, step_c, last_c;
    logic             load_c, load_dbz_c;
    logic [WIDTH-1:0] alu_res_c, iter_res_c, load_val_c;

    assign op_c         = alu_op_e'(alu_op_i);
    assign b_zero_c     = (b_i == '0);
    assign ready_o      = (state == ST_IDLE) || ((state == ST_DONE) && ready_i);
    assign accept_c     = valid_i && ready_o;
    assign step_c       = (state == ST_MUL) || (state == ST_DIV);
    assign iter_start_c = accept_c && ((op_c == OP_MUL) || ((op_c == OP_DIV) && !b_zero_c));

    // Single-cycle arithmetic; MUL/DIV come from the iterative datapath.
    always_comb begin
        alu_res_c = '0;
        case (op_c)
            OP_ADD, OP_LW, OP_SW: alu_res_c = a_i + b_i;
            OP_SUB, OP_BR:        alu_res_c = a_i - b_i;
            OP_J:                 alu_res_c = b_i;
            default:              alu_res_c = '0;
        endcase
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .start    (iter_start_c),
        .is_div   (op_c == OP_DIV),
        .step     (step_c),
        .a        (a_i),
        .b        (b_i),
        .result_c (iter_res_c),
        .last_c   (last_c)
    );

    // Next state plus the value loaded into the result registers.
    always_comb begin
        state_n    = state;
        load_c     = 1'b0;
        load_val_c = alu_res_c;
        load_dbz_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_i) begin
                    state_n = issue_state(op_c, b_zero_c);
                end
            end
            ST_MUL, ST_DIV: begin
                if (last_c) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_n = valid_i ? issue_state(op_c, b_zero_c) : ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (step_c && last_c) begin
            load_c     = 1'b1;
            load_val_c = iter_res_c;
        end else if (accept_c && !iter_start_c) begin
            load_c = 1'b1;
            if (op_c == OP_DIV) begin
                load_val_c = '1;
                load_dbz_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= ST_IDLE;
            valid_o       <= 1'b0;
            busy_o        <= 1'b0;
            result_o      <= '0;
            zero_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
        end else begin
            state   <= state_n;
            valid_o <= (state_n == ST_DONE);
            busy_o  <= (state_n == ST_MUL) || (state_n == ST_DIV);
            if (load_c) begin
                result_o      <= load_val_c;
                zero_o        <= (load_val_c == '0);
                div_by_zero_o <= load_dbz_c;
            end
        end
    end

endmodule
